// File: rtl/pulse_gen_pkg.sv
// Shared types and default field widths for the pulse train generator.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  localparam int DEF_W_HIGH = 4;
  localparam int DEF_W_LOW  = 4;
  localparam int DEF_W_CNT  = 4;

  // Wider of two field widths; sizes the shared phase counter.
  function automatic int max_width(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_train_generator_phase_counter.sv
// Loadable down-counter. Load wins over decrement. The counter holds at
// zero instead of wrapping. The zero and one flags let the owner detect
// the last cycle of a phase.
module phase_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero,
  output logic         one
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] value;

  // Count register: synchronous reset, then load, then saturating decrement.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec && (value != '0)) begin
      value <= value - ONE;
    end
  end

  assign zero = (value == '0);
  assign one  = (value == ONE);

endmodule

// File: rtl/pulse_train_generator.sv
// Pulse train generator. It accepts one request over valid/ready and then
// drives N pulses. Each pulse is H cycles high followed by L cycles low.
// pulse_out and done come straight from flops. req_ready is decoded from state.
module pulse_train_generator
  import pulse_gen_pkg::*;
#(
  parameter int W_HIGH = DEF_W_HIGH,
  parameter int W_LOW  = DEF_W_LOW,
  parameter int W_CNT  = DEF_W_CNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [W_HIGH-1:0] req_high,
  input  logic [W_LOW-1:0]  req_low,
  input  logic [W_CNT-1:0]  req_count,
  output logic              pulse_out,
  output logic              busy,
  output logic              done
);

  localparam int W_PH = max_width(W_HIGH, W_LOW);

  state_t state, state_next;

  logic [W_HIGH-1:0] high_len;
  logic [W_LOW-1:0]  low_len;
  logic [W_HIGH-1:0] clamped_high;
  logic [W_LOW-1:0]  clamped_low;

  logic            latch;
  logic            done_next;
  logic            ph_load;
  logic [W_PH-1:0] ph_value;
  logic            ph_dec;
  logic            ph_zero;
  logic            ph_one;
  logic            ph_expire;
  logic            rem_load;
  logic            rem_dec;
  logic            rem_zero;
  logic            rem_one_unused;

  // A zero-length phase would make a pulse invisible, so a zero field becomes 1.
  assign clamped_high = (req_high == '0) ? W_HIGH'(1) : req_high;
  assign clamped_low  = (req_low  == '0) ? W_LOW'(1)  : req_low;

  // The phase ends on its last counted cycle. Zero covers the post-reset value.
  assign ph_expire = ph_one | ph_zero;

  assign req_ready = (state == S_IDLE);
  assign busy      = ~req_ready;

  // Next-state, counter control and completion decode.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    latch      = 1'b0;
    done_next  = 1'b0;
    ph_load    = 1'b0;
    ph_value   = '0;
    ph_dec     = 1'b0;
    rem_load   = 1'b0;
    rem_dec    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          latch = 1'b1;
          if (req_count != '0) begin
            state_next = S_HIGH;
            ph_load    = 1'b1;
            ph_value   = W_PH'(clamped_high);
            rem_load   = 1'b1;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      S_HIGH: begin
        if (ph_expire) begin
          state_next = S_LOW;
          ph_load    = 1'b1;
          ph_value   = W_PH'(low_len);
          rem_dec    = 1'b1;
        end else begin
          ph_dec = 1'b1;
        end
      end
      S_LOW: begin
        if (ph_expire) begin
          if (rem_zero) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = S_HIGH;
            ph_load    = 1'b1;
            ph_value   = W_PH'(high_len);
          end
        end else begin
          ph_dec = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, latched request fields and the registered output pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      high_len  <= '0;
      low_len   <= '0;
      pulse_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      pulse_out <= (state_next == S_HIGH);
      done      <= done_next;
      if (latch) begin
        high_len <= clamped_high;
        low_len  <= clamped_low;
      end
    end
  end

  phase_counter #(.W(W_PH)) u_phase (
    .clk        (clk),
    .rst        (rst),
    .load       (ph_load),
    .load_value (ph_value),
    .dec        (ph_dec),
    .zero       (ph_zero),
    .one        (ph_one)
  );

  phase_counter #(.W(W_CNT)) u_remaining (
    .clk        (clk),
    .rst        (rst),
    .load       (rem_load),
    .load_value (req_count),
    .dec        (rem_dec),
    .zero       (rem_zero),
    .one        (rem_one_unused)
  );

endmodule
